pcrel_ctrl: RTL

Sequencing controller for the PC-relative execution unit (AUIPC/JAL/branch). It accepts issued instructions through a one-entry stage register, presents them to the combinational PC-relative unit, and checks each resolved outcome against the fetch-stage prediction. On a mispredict it raises a flush pulse and holds a redirect request to fetch until accepted. Instructions from the squashed path are discarded by epoch tag.

---
 rtl/pcrel_ctrl_if.sv | 55 +++++
 rtl/pcrel_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pcrel_ctrl_if.sv
// Bus bundle between the PC-relative sequencing controller and its neighbours:
// issue from the scheduler, stage contents to the combinational PC-relative
// unit, the unit's resolved result, writeback, and redirect toward fetch.
interface pcrel_ctrl_if #(
    parameter int XLEN    = 32,
    parameter int EPOCH_W = 2
);
    // issue handshake
    logic                issue_valid;
    logic                issue_ready;
    logic [XLEN-1:0]     issue_pc;
    logic                issue_is_branch;
    logic [4:0]          issue_rd;
    logic                issue_pred_taken;
    logic [XLEN-1:0]     issue_pred_target;
    logic [EPOCH_W-1:0]  issue_epoch;
    // stage contents to the PC-relative unit
    logic [XLEN-1:0]     ex_pc;
    logic [4:0]          ex_rd;
    // resolved outcome from the PC-relative unit
    logic                res_br_valid;
    logic [XLEN-1:0]     res_br_target;
    logic [XLEN-1:0]     res_rd_val;
    // writeback handshake
    logic                wb_valid;
    logic                wb_ready;
    logic [4:0]          wb_rd;
    logic [XLEN-1:0]     wb_val;
    // redirect handshake to fetch
    logic                redirect_valid;
    logic                redirect_ready;
    logic [XLEN-1:0]     redirect_target;

    // controller side
    modport slave (
        input  issue_valid, issue_pc, issue_is_branch, issue_rd,
               issue_pred_taken, issue_pred_target, issue_epoch,
               res_br_valid, res_br_target, res_rd_val,
               wb_ready, redirect_ready,
        output issue_ready, ex_pc, ex_rd,
               wb_valid, wb_rd, wb_val,
               redirect_valid, redirect_target
    );

    // environment side (scheduler, unit, writeback, fetch)
    modport master (
        output issue_valid, issue_pc, issue_is_branch, issue_rd,
               issue_pred_taken, issue_pred_target, issue_epoch,
               res_br_valid, res_br_target, res_rd_val,
               wb_ready, redirect_ready,
        input  issue_ready, ex_pc, ex_rd,
               wb_valid, wb_rd, wb_val,
               redirect_valid, redirect_target
    );
endinterface

// File: rtl/pcrel_ctrl.sv
// Sequencing controller for the PC-relative execution unit (AUIPC/JAL/branch).
// A one-entry stage register feeds the combinational unit; the resolved
// outcome is compared with the fetch prediction. A mispredict bumps the path
// epoch, pulses flush_out and holds a redirect until fetch accepts it.
// Entries tagged with an old epoch are silently discarded.
module pcrel_ctrl #(
    parameter int XLEN    = 32,
    parameter int EPOCH_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    pcrel_ctrl_if.slave        bus,
    input  logic               flush,
    output logic               flush_out,
    output logic [EPOCH_W-1:0] cur_epoch,
    output logic [CNT_W-1:0]   br_count,
    output logic [CNT_W-1:0]   mispred_count
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    // stage register
    logic               s_valid_r;
    logic [XLEN-1:0]    s_pc_r;
    logic               s_is_branch_r;
    logic [4:0]         s_rd_r;
    logic               s_pred_taken_r;
    logic [XLEN-1:0]    s_pred_target_r;
    logic [EPOCH_W-1:0] s_epoch_r;

    logic [EPOCH_W-1:0] cur_epoch_r;
    logic               flush_out_r;
    logic [XLEN-1:0]    redirect_target_r;
    logic [CNT_W-1:0]   br_count_r;
    logic [CNT_W-1:0]   mispred_count_r;

    logic               run_s;
    logic               s_stale_s;
    logic               s_drop_s;
    logic               wb_valid_s;
    logic               s_fire_s;
    logic               issue_ready_s;
    logic               issue_acc_s;
    logic               taken_s;
    logic [XLEN-1:0]    actual_s;
    logic               mispred_s;

    // Handshake qualifiers and resolve of the entry currently in the stage.
    always_comb begin
        run_s         = (state_r == ST_RUN);
        s_stale_s     = s_valid_r && (s_epoch_r != cur_epoch_r);
        s_drop_s      = s_stale_s && run_s;
        wb_valid_s    = s_valid_r && !s_stale_s && run_s &&
                        !s_is_branch_r && (s_rd_r != 5'd0);
        s_fire_s      = s_valid_r && !s_stale_s && run_s &&
                        (bus.wb_ready || !wb_valid_s);
        issue_ready_s = run_s && (!s_valid_r || s_fire_s || s_drop_s);
        issue_acc_s   = bus.issue_valid && issue_ready_s;
        taken_s       = bus.res_br_valid;
        if (taken_s) begin
            actual_s = bus.res_br_target;
        end else begin
            actual_s = s_pc_r + XLEN'(4);
        end
        mispred_s     = s_fire_s &&
                        ((taken_s != s_pred_taken_r) ||
                         (taken_s && (bus.res_br_target != s_pred_target_r)));
    end

    // Next-state logic: external flush always returns to RUN.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mispred_s) begin
                        state_nxt_s = ST_REDIRECT;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_REDIRECT: begin
                    if (bus.redirect_ready) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_REDIRECT;
                    end
                end
                default: state_nxt_s = ST_RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Stage register: load on accept, clear when consumed or flushed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_valid_r       <= 1'b0;
            s_pc_r          <= '0;
            s_is_branch_r   <= 1'b0;
            s_rd_r          <= 5'd0;
            s_pred_taken_r  <= 1'b0;
            s_pred_target_r <= '0;
            s_epoch_r       <= '0;
        end else if (flush) begin
            s_valid_r <= 1'b0;
        end else if (issue_acc_s) begin
            s_valid_r       <= 1'b1;
            s_pc_r          <= bus.issue_pc;
            s_is_branch_r   <= bus.issue_is_branch;
            s_rd_r          <= bus.issue_rd;
            s_pred_taken_r  <= bus.issue_pred_taken;
            s_pred_target_r <= bus.issue_pred_target;
            s_epoch_r       <= bus.issue_epoch;
        end else if (s_fire_s || s_drop_s) begin
            s_valid_r <= 1'b0;
        end else begin
            s_valid_r <= s_valid_r;
        end
    end

    // Epoch, flush pulse and redirect target bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_epoch_r       <= '0;
            flush_out_r       <= 1'b0;
            redirect_target_r <= '0;
        end else if (flush) begin
            cur_epoch_r <= cur_epoch_r + EPOCH_W'(1);
            flush_out_r <= 1'b0;
        end else if (mispred_s) begin
            cur_epoch_r       <= cur_epoch_r + EPOCH_W'(1);
            flush_out_r       <= 1'b1;
            redirect_target_r <= actual_s;
        end else begin
            flush_out_r <= 1'b0;
        end
    end

    // Performance counters; a flush suppresses any update that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_count_r      <= '0;
            mispred_count_r <= '0;
        end else if (flush) begin
            br_count_r      <= br_count_r;
            mispred_count_r <= mispred_count_r;
        end else begin
            if (s_fire_s && (taken_s || s_is_branch_r)) begin
                br_count_r <= br_count_r + CNT_W'(1);
            end else begin
                br_count_r <= br_count_r;
            end
            if (mispred_s) begin
                mispred_count_r <= mispred_count_r + CNT_W'(1);
            end else begin
                mispred_count_r <= mispred_count_r;
            end
        end
    end

    assign bus.issue_ready     = issue_ready_s;
    assign bus.ex_pc           = s_pc_r;
    assign bus.ex_rd           = s_rd_r;
    assign bus.wb_valid        = wb_valid_s;
    assign bus.wb_rd           = s_rd_r;
    assign bus.wb_val          = bus.res_rd_val;
    assign bus.redirect_valid  = (state_r == ST_REDIRECT);
    assign bus.redirect_target = redirect_target_r;
    assign flush_out           = flush_out_r;
    assign cur_epoch           = cur_epoch_r;
    assign br_count            = br_count_r;
    assign mispred_count       = mispred_count_r;

endmodule
